// File: rtl/wb_result_checker.sv
// wb_result_checker: synthesizable consumer of the pipeline writeback stream.
// A loadable table of expected results, each entry with a care bit, is
// compared in order against every valid writeback after a pipeline-fill
// delay. The checker reports pass/fail, match/error counts and the index
// and data of the first mismatch.
// Optional build macro WB_CHECK_STOP_ON_FAIL_EN: when defined, the first
// mismatch ends the session immediately instead of checking all entries.
module wb_result_checker #(
  parameter int DEPTH       = 32,
  parameter int IDX_W       = 5,
  parameter int START_DELAY = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             exp_we,
  input  logic [IDX_W-1:0] exp_addr,
  input  logic [31:0]      exp_data,
  input  logic             exp_care,
  input  logic [IDX_W:0]   exp_len,
  input  logic             wb_valid,
  input  logic [31:0]      result_w,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [IDX_W-1:0] err_idx,
  output logic [31:0]      err_data
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DELAY = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [15:0]      DELAY_INIT = 16'(START_DELAY);
  localparam logic [15:0]      DELAY_ONE  = 16'd1;
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [IDX_W-1:0] IDX_ONE    = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W:0]   LEN_ONE    = {{IDX_W{1'b0}}, 1'b1};

  logic [1:0]       state;
  logic [15:0]      delay_cnt;
  logic [IDX_W-1:0] idx;
  logic [IDX_W:0]   len;
  logic [DEPTH-1:0] care_bits;
  logic [31:0]      exp_mem [DEPTH];

  logic table_wr;
  logic entry_hit;
  logic last_entry;
  logic session_end;

  assign table_wr   = exp_we && ((state == ST_IDLE) || (state == ST_DONE));
  // Four-state equality so an X/Z result never matches a cared-for entry.
  assign entry_hit  = !care_bits[idx] || (result_w === exp_mem[idx]);
  assign last_entry = ({1'b0, idx} == (len - LEN_ONE));

`ifdef WB_CHECK_STOP_ON_FAIL_EN
  assign session_end = last_entry || !entry_hit;
`else
  assign session_end = last_entry;
`endif

  // Expected-value storage; deliberately not reset so it is plain RAM.
  always_ff @(posedge clk) begin
    if (table_wr) begin
      exp_mem[exp_addr] <= exp_data;
    end
  end

  // Care bits are cleared by reset, which forces a table reload afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      care_bits <= '0;
    end else if (table_wr) begin
      care_bits[exp_addr] <= exp_care;
    end
  end

  // Session state machine with registered status, counters and first-error capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      delay_cnt <= '0;
      idx       <= '0;
      len       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      match_cnt <= '0;
      err_cnt   <= '0;
      err_idx   <= '0;
      err_data  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            match_cnt <= '0;
            err_cnt   <= '0;
            err_idx   <= '0;
            err_data  <= '0;
            idx       <= '0;
            len       <= exp_len;
            if (exp_len == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
              pass  <= 1'b1;
              busy  <= 1'b0;
            end else if (START_DELAY == 0) begin
              state <= ST_CHECK;
              busy  <= 1'b1;
            end else begin
              state     <= ST_DELAY;
              delay_cnt <= DELAY_INIT;
              busy      <= 1'b1;
            end
          end
        end

        ST_DELAY: begin
          if (delay_cnt <= DELAY_ONE) begin
            delay_cnt <= '0;
            state     <= ST_CHECK;
          end else begin
            delay_cnt <= delay_cnt - DELAY_ONE;
          end
        end

        ST_CHECK: begin
          if (wb_valid) begin
            if (entry_hit) begin
              if (match_cnt != CNT_MAX) begin
                match_cnt <= match_cnt + CNT_ONE;
              end
            end else begin
              if (err_cnt != CNT_MAX) begin
                err_cnt <= err_cnt + CNT_ONE;
              end
              fail <= 1'b1;
              if (!fail) begin
                err_idx  <= idx;
                err_data <= result_w;
              end
            end
            idx <= idx + IDX_ONE;
            if (session_end) begin
              state <= ST_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
              pass  <= entry_hit && !fail;
            end
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_result_checker.sv
// tb_wb_result_checker: scoreboard bench for wb_result_checker.
// Each driven writeback pushes the expected counters and done flag to a
// queue; the entry is popped and compared after the DUT's capture edge.
// Honors WB_CHECK_STOP_ON_FAIL_EN in its reference model.
module tb_wb_result_checker;

  localparam int DEPTH       = 32;
  localparam int IDX_W       = 5;
  localparam int START_DELAY = 4;
  localparam int CNT_W       = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             exp_we;
  logic [IDX_W-1:0] exp_addr;
  logic [31:0]      exp_data;
  logic             exp_care;
  logic [IDX_W:0]   exp_len;
  logic             wb_valid;
  logic [31:0]      result_w;
  logic             busy;
  logic             done;
  logic             pass;
  logic             fail;
  logic [CNT_W-1:0] match_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [IDX_W-1:0] err_idx;
  logic [31:0]      err_data;

  int errors = 0;
  int checks = 0;

  // Reference model of the table and of the running session.
  logic [31:0] tab_data [DEPTH];
  logic        tab_care [DEPTH];
  int          m_idx;
  int          m_len;
  int          m_match;
  int          m_err;
  logic        m_fail;
  logic        m_done;
  int          m_eidx;
  logic [31:0] m_edata;

  typedef struct packed {
    logic [CNT_W-1:0] mc;
    logic [CNT_W-1:0] ec;
    logic             dn;
  } sb_t;

  sb_t sb_q[$];

  wb_result_checker #(
    .DEPTH(DEPTH), .IDX_W(IDX_W), .START_DELAY(START_DELAY), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .exp_we(exp_we),
    .exp_addr(exp_addr), .exp_data(exp_data), .exp_care(exp_care),
    .exp_len(exp_len), .wb_valid(wb_valid), .result_w(result_w),
    .busy(busy), .done(done), .pass(pass), .fail(fail),
    .match_cnt(match_cnt), .err_cnt(err_cnt), .err_idx(err_idx),
    .err_data(err_data)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    m_idx = 0; m_len = 0; m_match = 0; m_err = 0;
    m_fail = 1'b0; m_done = 1'b0; m_eidx = 0; m_edata = '0;
    sb_q.delete();
  endtask

  task automatic load_entry(input int addr, input logic [31:0] data, input logic care);
    exp_we = 1'b1; exp_addr = addr[IDX_W-1:0]; exp_data = data; exp_care = care;
    @(posedge clk); #1;
    exp_we = 1'b0;
    tab_data[addr] = data;
    tab_care[addr] = care;
  endtask

  task automatic start_session(input int len);
    model_clear();
    m_len = len;
    m_done = (len == 0);
    exp_len = len[IDX_W:0];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_delay(input logic v, input logic [31:0] d);
    for (int i = 0; i < START_DELAY; i++) begin
      wb_valid = v; result_w = d;
      @(posedge clk); #1;
    end
    wb_valid = 1'b0;
  endtask

  task automatic send(input logic v, input logic [31:0] d);
    logic hit;
    sb_t  e;
    wb_valid = v; result_w = d;
    if (v && !m_done) begin
      hit = !tab_care[m_idx] || (d === tab_data[m_idx]);
      if (hit) begin
        m_match++;
      end else begin
        if (!m_fail) begin
          m_eidx = m_idx;
          m_edata = d;
        end
        m_fail = 1'b1;
        m_err++;
`ifdef WB_CHECK_STOP_ON_FAIL_EN
        m_done = 1'b1;
`endif
      end
      if (m_idx == m_len - 1) m_done = 1'b1;
      m_idx++;
    end
    e.mc = m_match[CNT_W-1:0];
    e.ec = m_err[CNT_W-1:0];
    e.dn = m_done;
    sb_q.push_back(e);
    @(posedge clk); #1;
    wb_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, done, pass, fail, match_cnt, err_cnt, err_idx, err_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b pass=%b fail=%b mc=%0d ec=%0d, expected all 0",
               busy, done, pass, fail, match_cnt, err_cnt);
    end
  endtask

  task automatic test_basic();
    sb_t got;
    sb_t want;
    for (int i = 0; i < 5; i++) load_entry(i, 32'd11 + i, 1'b1);
    start_session(5);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL basic_busy: got %b, expected 1", busy);
    end
    run_delay(1'b0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      send(1'b1, 32'd11 + i);
      got = {match_cnt, err_cnt, done};
      want = sb_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL basic_sample%0d: got mc=%0d ec=%0d done=%b, expected mc=%0d ec=%0d done=%b",
                 i, got.mc, got.ec, got.dn, want.mc, want.ec, want.dn);
      end
    end
    checks++;
    if ({done, pass, busy, fail} !== 4'b1100 || match_cnt !== 8'd5 || err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL basic_final: got done=%b pass=%b busy=%b fail=%b mc=%0d ec=%0d, expected 1 1 0 0 5 0",
               done, pass, busy, fail, match_cnt, err_cnt);
    end
  endtask

  task automatic test_dont_care();
    logic [31:0] stim [5];
    sb_t got;
    sb_t want;
    stim[0] = 32'd28; stim[1] = 32'hDEADBEEF; stim[2] = 32'd65536;
    stim[3] = 32'hXXXXXXXX; stim[4] = 32'd0;
    load_entry(0, 32'd28, 1'b1);
    load_entry(1, 32'h1234, 1'b0);
    load_entry(2, 32'd65536, 1'b1);
    load_entry(3, 32'h5678, 1'b0);
    load_entry(4, 32'd0, 1'b1);
    start_session(5);
    run_delay(1'b0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      send(1'b1, stim[i]);
      got = {match_cnt, err_cnt, done};
      want = sb_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL dc_sample%0d: got mc=%0d ec=%0d done=%b, expected mc=%0d ec=%0d done=%b",
                 i, got.mc, got.ec, got.dn, want.mc, want.ec, want.dn);
      end
    end
    checks++;
    if (pass !== 1'b1 || match_cnt !== 8'd5) begin
      errors++; $display("FAIL dc_final: got pass=%b mc=%0d, expected pass=1 mc=5", pass, match_cnt);
    end
  endtask

  task automatic test_mismatch();
    logic [31:0] stim [3];
    sb_t got;
    sb_t want;
    stim[0] = 32'd7; stim[1] = 32'd29; stim[2] = 32'd9;
    load_entry(0, 32'd7, 1'b1);
    load_entry(1, 32'd28, 1'b1);
    load_entry(2, 32'd9, 1'b1);
    start_session(3);
    run_delay(1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      if (!m_done) begin
        send(1'b1, stim[i]);
        got = {match_cnt, err_cnt, done};
        want = sb_q.pop_front();
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL mis_sample%0d: got mc=%0d ec=%0d done=%b, expected mc=%0d ec=%0d done=%b",
                   i, got.mc, got.ec, got.dn, want.mc, want.ec, want.dn);
        end
      end
    end
    // A writeback after the session ends must leave everything untouched.
    send(1'b1, 32'd555);
    got = {match_cnt, err_cnt, done};
    want = sb_q.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL mis_after_done: got mc=%0d ec=%0d done=%b, expected mc=%0d ec=%0d done=%b",
               got.mc, got.ec, got.dn, want.mc, want.ec, want.dn);
    end
    checks++;
    if (fail !== 1'b1 || pass !== 1'b0 || err_idx !== m_eidx[IDX_W-1:0] || err_data !== m_edata
        || err_cnt !== 8'd1) begin
      errors++;
      $display("FAIL mis_final: got fail=%b pass=%b idx=%0d data=%0d ec=%0d, expected 1 0 %0d %0d 1",
               fail, pass, err_idx, err_data, err_cnt, m_eidx, m_edata);
    end
  endtask

  task automatic test_bubbles();
    logic vpat [9];
    int   k;
    sb_t  got;
    sb_t  want;
    vpat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) load_entry(i, 32'h100 + i, 1'b1);
    start_session(5);
    run_delay(1'b1, 32'h100);
    checks++;
    if (match_cnt !== 8'd0 || err_cnt !== 8'd0) begin
      errors++; $display("FAIL bub_delay: got mc=%0d ec=%0d, expected 0 0", match_cnt, err_cnt);
    end
    k = 0;
    for (int i = 0; i < 9; i++) begin
      send(vpat[i], vpat[i] ? 32'h100 + k : 32'hBAD0BAD0);
      if (vpat[i]) k++;
      got = {match_cnt, err_cnt, done};
      want = sb_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL bub_sample%0d: got mc=%0d ec=%0d done=%b, expected mc=%0d ec=%0d done=%b",
                 i, got.mc, got.ec, got.dn, want.mc, want.ec, want.dn);
      end
    end
    checks++;
    if (pass !== 1'b1 || match_cnt !== 8'd5) begin
      errors++; $display("FAIL bub_final: got pass=%b mc=%0d, expected 1 5", pass, match_cnt);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) load_entry(i, 32'h200 + i, 1'b1);
    start_session(5);
    run_delay(1'b0, 32'd0);
    send(1'b1, 32'h200);
    send(1'b1, 32'h201);
    sb_q.delete();
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, pass, fail, match_cnt, err_cnt, err_idx, err_data} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got busy=%b done=%b mc=%0d ec=%0d, expected all 0",
               busy, done, match_cnt, err_cnt);
    end
    #2 reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) tab_care[i] = 1'b0;
    @(posedge clk); #1;
    // Care bits were cleared, so an unloaded entry accepts any value.
    start_session(1);
    run_delay(1'b0, 32'd0);
    send(1'b1, 32'hFFFF0000);
    void'(sb_q.pop_front());
    checks++;
    if (pass !== 1'b1 || match_cnt !== 8'd1) begin
      errors++; $display("FAIL midreset_care_cleared: got pass=%b mc=%0d, expected 1 1", pass, match_cnt);
    end
    for (int i = 0; i < 5; i++) load_entry(i, 32'h200 + i, 1'b1);
    start_session(5);
    run_delay(1'b0, 32'd0);
    for (int i = 0; i < 5; i++) send(1'b1, 32'h200 + i);
    sb_q.delete();
    checks++;
    if (pass !== 1'b1 || match_cnt !== 8'd5 || done !== 1'b1) begin
      errors++;
      $display("FAIL midreset_rerun: got pass=%b mc=%0d done=%b, expected 1 5 1", pass, match_cnt, done);
    end
  endtask

  task automatic test_zero_len();
    start_session(0);
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0 || match_cnt !== 8'd0) begin
      errors++;
      $display("FAIL zero_len: got done=%b pass=%b busy=%b mc=%0d, expected 1 1 0 0",
               done, pass, busy, match_cnt);
    end
  endtask

  task automatic test_ignore_in_check();
    for (int i = 0; i < 3; i++) load_entry(i, 32'd1 + i, 1'b1);
    start_session(3);
    run_delay(1'b0, 32'd0);
    send(1'b1, 32'd1);
    void'(sb_q.pop_front());
    start = 1'b1; exp_len = '0;
    exp_we = 1'b1; exp_addr = 5'd1; exp_data = 32'd99; exp_care = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; exp_we = 1'b0;
    checks++;
    if (busy !== 1'b1 || match_cnt !== 8'd1 || done !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start: got busy=%b mc=%0d done=%b, expected 1 1 0", busy, match_cnt, done);
    end
    send(1'b1, 32'd2);
    send(1'b1, 32'd3);
    sb_q.delete();
    checks++;
    if (pass !== 1'b1 || match_cnt !== 8'd3 || err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL ignore_write: got pass=%b mc=%0d ec=%0d, expected 1 3 0", pass, match_cnt, err_cnt);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_data = '0;
    exp_care = 1'b0; exp_len = '0; wb_valid = 1'b0; result_w = '0;
    for (int i = 0; i < DEPTH; i++) begin
      tab_data[i] = '0;
      tab_care[i] = 1'b0;
    end
    model_clear();
    #12;
    test_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    test_basic();
    test_dont_care();
    test_mismatch();
    test_bubbles();
    test_reset_mid();
    test_zero_len();
    test_ignore_in_check();
    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_result_checker.md
Name: wb_result_checker

Overview:
- Self-checking consumer of the pipeline's writeback stream (result_w), synthesizable.
- Holds a loadable table of expected writeback values, each entry with a care bit.
- Compares each valid writeback in order and reports pass/fail, match/error counts and first-failure details.
- Sits beside the pipeline top in FPGA/emulation builds, replacing bench-side expected-value sequencing.

Parameters:
- DEPTH, 32, number of expected-value entries.
- IDX_W, 5, index width; DEPTH <= 2**IDX_W.
- START_DELAY, 4, cycles after start before writebacks are checked (pipeline fill).
- CNT_W, 8, width of match/error counters.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle pulse; begins a check session.
- exp_we  in  1  table write enable.
- exp_addr  in  IDX_W  table write index.
- exp_data  in  32  expected value.
- exp_care  in  1  1 = compare; 0 = don't-care entry.
- exp_len  in  IDX_W+1  entries to check, 0..DEPTH; sampled on start.
- wb_valid  in  1  writeback stage is retiring a result this cycle.
- result_w  in  32  writeback result.
- busy  out  1  session in progress (DELAY or CHECK).
- done  out  1  session finished; held until next start or reset.
- pass  out  1  done and err_cnt == 0.
- fail  out  1  at least one mismatch this session; sticky.
- match_cnt  out  CNT_W  compared-or-don't-care entries accepted.
- err_cnt  out  CNT_W  mismatching entries.
- err_idx  out  IDX_W  index of first mismatch.
- err_data  out  32  result_w value at first mismatch.

Behaviour:
- Reset (async): all outputs 0; state IDLE; idx, delay counter and latched length cleared; all care bits cleared to 0; exp_data storage not reset.
- States: IDLE, DELAY, CHECK, DONE.
- Table writes: accepted in IDLE and DONE only; ignored in DELAY and CHECK. A write and start in the same cycle: write lands first, start proceeds.
- start in IDLE or DONE:
  - Clears done, pass, fail, both counters, err_idx and err_data; idx = 0; latches exp_len.
  - Next state is DELAY with counter = START_DELAY. If START_DELAY = 0, next state is CHECK. If latched length = 0, next state is DONE and done = pass = 1 on the following edge.
- start in DELAY or CHECK: ignored.
- DELAY: counts down once per cycle; wb_valid ignored; enters CHECK when count reaches 0.
- CHECK:
  - Each edge with wb_valid = 1 consumes entry[idx].
  - care = 0, or result_w equals exp_data: match_cnt increments.
  - Otherwise err_cnt increments and fail = 1; on the first error also err_idx = idx and err_data = result_w.
  - An X/Z bit in result_w against a care entry is a mismatch (4-state compare in simulation).
  - wb_valid = 0: no state change; idx holds.
  - After consuming idx = len-1, next state is DONE.
- DONE: done = 1, pass = (err_cnt == 0), busy = 0, all outputs stable.
- Timing: all outputs registered; counters and flags reflect a sample one cycle after its capture edge; done rises on the edge that consumes the last entry.
- Counters saturate at 2**CNT_W-1; no wrap.
- Reset mid-session aborts immediately; the table's exp_data survives but care bits are cleared, so the table must be reloaded.

Optional Feature:
- Macro: WB_CHECK_STOP_ON_FAIL_EN.
- Defined: the first mismatch moves CHECK to DONE on the same edge. done = 1, fail = 1, err_cnt = 1; later writebacks are ignored.
- Undefined: checking continues through all len entries; err_cnt accumulates every mismatch.

Test Plan:
- Load 11,12,13,14,15 (care = 1), exp_len = 5, START_DELAY = 4, pulse start, drive wb_valid with 11..15 after the delay -> done = 1, pass = 1, match_cnt = 5, err_cnt = 0, busy = 0.
- Entries {28, dc, 65536, dc, 0}, drive 28, 0xDEADBEEF, 65536, 32'hXXXXXXXX, 0 -> pass = 1, match_cnt = 5.
- Entries {7, 28, 9}, drive 7, 29, 9 -> fail = 1, err_idx = 1, err_data = 29.
  - Macro undefined: err_cnt = 1, match_cnt = 2, done after the third sample.
  - Macro defined: done after the second sample, match_cnt = 1.
- Drive wb_valid = 1 during DELAY and insert wb_valid = 0 bubbles in CHECK -> DELAY samples not counted, bubbles do not advance idx, final pass = 1.
- Assert reset after 2 of 5 samples -> all outputs 0 asynchronously. Reload the table, restart -> full pass.
- exp_len = 0 with start -> done = pass = 1 one cycle later. start and exp_we during CHECK -> ignored, result unchanged.
